// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path.
package regfile_pkg;
  typedef logic [4:0]  reg_idx_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_A, SRC_B, SRC_C} wb_src_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy bits for destinations still owed by the load and mult/div units.
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_reg,
  input  logic     clr_en,
  input  reg_idx_t clr_reg,
  input  reg_idx_t query_index1,
  input  reg_idx_t query_index2,
  output logic     query_busy1,
  output logic     query_busy2
);
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // Clear is applied before set so a new producer issued on the same edge stays outstanding.
  always_comb begin
    busy_next = busy;
    if (clr_en)
      busy_next[clr_reg] = 1'b0;
    if (set_en && (set_reg != REG_ZERO))
      busy_next[set_reg] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

  assign query_busy1 = busy[query_index1] & (query_index1 != REG_ZERO);
  assign query_busy2 = busy[query_index2] & (query_index2 != REG_ZERO);
endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Arbitrates pipeline, load and mult/div writebacks onto the single register-file write port.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  input  logic        c_valid,
  output logic        c_ready,
  input  logic [4:0]  c_reg,
  input  logic [31:0] c_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_reg,
  input  logic [4:0]  query_index1,
  input  logic [4:0]  query_index2,
  output logic        query_busy1,
  output logic        query_busy2,
  output logic        stall_req,
  output logic        rf_write_enable,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data
);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  wb_src_t  src;
  reg_idx_t win_reg;
  word_t    win_data;
  logic     rr_is_b;
  logic     from_bc;
  logic     bc_hs;
  logic [7:0] starve_cnt;
  logic [7:0] starve_next;

  always_comb begin
    src     = SRC_NONE;
    b_ready = 1'b0;
    c_ready = 1'b0;
    if (!reset) begin
      if (a_valid) begin
        src = SRC_A;
      end else if (b_valid && (!c_valid || rr_is_b)) begin
        src     = SRC_B;
        b_ready = 1'b1;
      end else if (c_valid) begin
        src     = SRC_C;
        c_ready = 1'b1;
      end
    end
  end

  always_comb begin
    win_reg  = REG_ZERO;
    win_data = '0;
    case (src)
      SRC_A:   begin win_reg = a_reg; win_data = a_data; end
      SRC_B:   begin win_reg = b_reg; win_data = b_data; end
      SRC_C:   begin win_reg = c_reg; win_data = c_data; end
      default: ;
    endcase
  end

  assign bc_hs = (src == SRC_B) || (src == SRC_C);

  // Output stage: one registered slot toward the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_reg    <= REG_ZERO;
      rf_write_data   <= '0;
      from_bc         <= 1'b0;
    end else begin
      rf_write_enable <= (src != SRC_NONE) && (win_reg != REG_ZERO);
      from_bc         <= bc_hs;
      if ((src != SRC_NONE) && (win_reg != REG_ZERO)) begin
        rf_write_reg  <= win_reg;
        rf_write_data <= win_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rr_is_b <= 1'b1;
    else if (bc_hs)
      rr_is_b <= ~rr_is_b;
  end

  always_comb begin
    starve_next = starve_cnt;
    if (bc_hs || !(b_valid || c_valid))
      starve_next = '0;
    else if (starve_cnt != LIMIT)
      starve_next = starve_cnt + 8'd1;
  end

  // stall_req holds until the edge that closes the next B/C handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      if (bc_hs)
        stall_req <= 1'b0;
      else if (starve_next == LIMIT)
        stall_req <= 1'b1;
    end
  end

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (issue_valid),
    .set_reg      (issue_reg),
    .clr_en       (rf_write_enable & from_bc),
    .clr_reg      (rf_write_reg),
    .query_index1 (query_index1),
    .query_index2 (query_index2),
    .query_busy1  (query_busy1),
    .query_busy2  (query_busy2)
  );
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter with hand-computed expectations.
module tb_regfile_writeback_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, c_valid;
  logic        b_ready, c_ready;
  logic [4:0]  a_reg, b_reg, c_reg;
  logic [31:0] a_data, b_data, c_data;
  logic        issue_valid;
  logic [4:0]  issue_reg, query_index1, query_index2;
  logic        query_busy1, query_busy2, stall_req;
  logic        rf_write_enable;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.STARVE_LIMIT(8), .NUM_REGS(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .a_valid         (a_valid),
    .a_reg           (a_reg),
    .a_data          (a_data),
    .b_valid         (b_valid),
    .b_ready         (b_ready),
    .b_reg           (b_reg),
    .b_data          (b_data),
    .c_valid         (c_valid),
    .c_ready         (c_ready),
    .c_reg           (c_reg),
    .c_data          (c_data),
    .issue_valid     (issue_valid),
    .issue_reg       (issue_reg),
    .query_index1    (query_index1),
    .query_index2    (query_index2),
    .query_busy1     (query_busy1),
    .query_busy2     (query_busy2),
    .stall_req       (stall_req),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; c_valid = 0;
    a_reg = 0; b_reg = 0; c_reg = 0;
    a_data = 0; b_data = 0; c_data = 0;
    issue_valid = 0; issue_reg = 0;
    query_index1 = 0; query_index2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
    settle();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    b_valid = 1;
    settle();
    check("reset_b_ready", b_ready, 0);
    step();
    check("reset_we", rf_write_enable, 0);
    check("reset_wreg", rf_write_reg, 0);
    check("reset_wdata", rf_write_data, 0);
    check("reset_stall", stall_req, 0);

    // Single load writeback.
    do_reset();
    b_valid = 1; b_reg = 5; b_data = 32'hDEADBEEF;
    settle();
    check("b_only_ready", b_ready, 1);
    check("b_only_c_ready", c_ready, 0);
    step();
    b_valid = 0;
    check("b_only_we", rf_write_enable, 1);
    check("b_only_wreg", rf_write_reg, 5);
    check("b_only_wdata", rf_write_data, 32'hDEADBEEF);
    step();
    check("b_only_we_off", rf_write_enable, 0);
    check("b_only_hold_reg", rf_write_reg, 5);

    // A wins three times, then B/C alternate starting from B.
    do_reset();
    b_valid = 1; b_reg = 3; b_data = 32'h0000B0B0;
    c_valid = 1; c_reg = 4; c_data = 32'h0000C0C0;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_reg = 1; a_data = 32'hA0 + i;
      settle();
      check("a_pri_b_ready", b_ready, 0);
      check("a_pri_c_ready", c_ready, 0);
      step();
      check("a_pri_wreg", rf_write_reg, 1);
      check("a_pri_wdata", rf_write_data, 32'hA0 + i);
    end
    a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("rr_b_ready", b_ready, (i != 1) ? 1 : 0);
      check("rr_c_ready", c_ready, (i == 1) ? 1 : 0);
      step();
      check("rr_we", rf_write_enable, 1);
      check("rr_wreg", rf_write_reg, (i == 1) ? 4 : 3);
      check("rr_wdata", rf_write_data, (i == 1) ? 32'h0000C0C0 : 32'h0000B0B0);
    end
    b_valid = 0; c_valid = 0;
    step();
    check("rr_idle_we", rf_write_enable, 0);

    // Scoreboard set and clear by a C writeback.
    do_reset();
    issue_valid = 1; issue_reg = 7; query_index1 = 7; query_index2 = 7;
    step();
    issue_valid = 0;
    check("sb_busy1_set", query_busy1, 1);
    check("sb_busy2_set", query_busy2, 1);
    c_valid = 1; c_reg = 7; c_data = 32'h77;
    settle();
    check("sb_c_ready", c_ready, 1);
    step();
    c_valid = 0;
    check("sb_out_we", rf_write_enable, 1);
    check("sb_busy_output_edge", query_busy1, 1);
    step();
    check("sb_busy_cleared", query_busy1, 0);
    // Same-edge set and clear keeps the register busy.
    issue_valid = 1; issue_reg = 7;
    step();
    issue_valid = 0;
    c_valid = 1; c_reg = 7; c_data = 32'h78;
    step();
    c_valid = 0;
    issue_valid = 1; issue_reg = 7;
    check("sb_same_we", rf_write_enable, 1);
    step();
    issue_valid = 0;
    check("sb_same_edge_busy", query_busy1, 1);
    step();
    check("sb_same_edge_busy_hold", query_busy1, 1);

    // Starvation: A held, B denied.
    do_reset();
    a_valid = 1; a_reg = 1; a_data = 32'h11;
    b_valid = 1; b_reg = 2; b_data = 32'h22;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) check("starve_7_stall", stall_req, 0);
      if (i == 8) check("starve_8_stall", stall_req, 1);
    end
    settle();
    check("starve_a_still_wins", b_ready, 0);
    a_valid = 0;
    settle();
    check("starve_b_ready", b_ready, 1);
    step();
    check("starve_stall_drop", stall_req, 0);
    check("starve_b_write", rf_write_reg, 2);
    a_valid = 1;
    for (int i = 1; i <= 7; i++) step();
    check("starve_cnt_restart", stall_req, 0);
    step();
    check("starve_cnt_reach", stall_req, 1);

    // Writes and issues to register 0.
    do_reset();
    c_valid = 1; c_reg = 0; c_data = 32'h1234;
    settle();
    check("r0_c_ready", c_ready, 1);
    step();
    c_valid = 0;
    check("r0_we", rf_write_enable, 0);
    check("r0_hold_data", rf_write_data, 0);
    issue_valid = 1; issue_reg = 0; query_index1 = 0;
    step();
    issue_valid = 0;
    check("r0_busy", query_busy1, 0);

    // Reset mid-operation.
    do_reset();
    issue_valid = 1; issue_reg = 9; query_index1 = 9;
    step();
    issue_valid = 0;
    check("mid_busy_pre", query_busy1, 1);
    b_valid = 1; b_reg = 9; b_data = 32'h99;
    step();
    check("mid_we_pending", rf_write_enable, 1);
    #2;
    reset = 1;
    #1;
    check("mid_we", rf_write_enable, 0);
    check("mid_busy", query_busy1, 0);
    check("mid_stall", stall_req, 0);
    check("mid_b_ready", b_ready, 0);
    reset = 0;
    idle_inputs();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
